// File: rtl/pulse_voice_adsr_if.sv
// rtl/pulse_voice_adsr_if.sv - sequencer-to-voice control and audio result bundle
interface pulse_voice_adsr_if #(
  parameter int PHASE_BITS = 18,
  parameter int AMP_BITS   = 8,
  parameter int OUT_BITS   = 13
);
  logic                  sample_clk;
  logic                  tick_clk;
  logic                  song_clk;
  logic                  note_on;
  logic                  note_trigger;
  logic [PHASE_BITS-1:0] phase_inc;
  logic [3:0]            pulse_width;
  logic [3:0]            attack_rate;
  logic [3:0]            decay_rate;
  logic [3:0]            release_rate;
  logic [AMP_BITS-1:0]   sustain_level;
  logic [2:0]            env_state;
  logic                  busy;
  logic [OUT_BITS-1:0]   audio_out;

  modport master (
    output sample_clk, tick_clk, song_clk, note_on, note_trigger, phase_inc,
           pulse_width, attack_rate, decay_rate, release_rate, sustain_level,
    input  env_state, busy, audio_out
  );

  modport slave (
    input  sample_clk, tick_clk, song_clk, note_on, note_trigger, phase_inc,
           pulse_width, attack_rate, decay_rate, release_rate, sustain_level,
    output env_state, busy, audio_out
  );
endinterface

// File: rtl/pulse_voice_adsr.sv
// rtl/pulse_voice_adsr.sv - stacked pulse oscillators sharing one ADSR envelope
module pulse_voice_adsr #(
  parameter int PHASE_BITS    = 18,
  parameter int NUM_OSC       = 2,
  parameter int DETUNE        = 2,
  parameter int CARRIER_SHIFT = 1,
  parameter int AMP_BITS      = 8,
  parameter int OUT_BITS      = 13,
  parameter int PHASE_RESET   = 0
) (
  input logic              clk,
  input logic              rst,
  pulse_voice_adsr_if.slave bus
);
  localparam int W = AMP_BITS + 16;
  localparam logic [AMP_BITS-1:0] MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_t;

  env_t                  state;
  logic [AMP_BITS-1:0]   amp;
  logic [PHASE_BITS-1:0] phase [NUM_OSC];
  logic [PHASE_BITS-1:0] inc   [NUM_OSC];
  logic [NUM_OSC-1:0]    pulse;
  logic [OUT_BITS-1:0]   mix;
  logic [AMP_BITS-1:0]   att_amp;
  logic [AMP_BITS-1:0]   dec_amp;
  logic [AMP_BITS-1:0]   rel_amp;
  logic                  trigger;
  logic                  rel_now;

  // Rounding up keeps every step at least 1 while never passing the target.
  function automatic logic [AMP_BITS-1:0] ceil_shr(input logic [AMP_BITS-1:0] x,
                                                   input logic [3:0] r);
    logic [W-1:0] t;
    t = (W'(x) + (W'(1) << r) - W'(1)) >> r;
    return AMP_BITS'(t);
  endfunction

  always_comb begin
    mix = '0;
    for (int k = 0; k < NUM_OSC; k++) begin
      inc[k]   = PHASE_BITS'(bus.phase_inc << (k * CARRIER_SHIFT)) + PHASE_BITS'(k * DETUNE);
      pulse[k] = phase[k][PHASE_BITS-1 -: 4] < bus.pulse_width;
      if (pulse[k]) mix = mix + OUT_BITS'(amp);
    end
  end

  always_comb begin
    att_amp = amp + ceil_shr(MAX - amp, bus.attack_rate);
    dec_amp = (amp > bus.sustain_level)
            ? amp - ceil_shr(amp - bus.sustain_level, bus.decay_rate) : amp;
    rel_amp = amp - ceil_shr(amp, bus.release_rate);
  end

  assign trigger = bus.tick_clk & bus.song_clk & bus.note_trigger;
  assign rel_now = (state == RELEASE) ||
                   (!bus.note_on && (state == ATTACK || state == DECAY || state == SUSTAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      amp   <= '0;
      for (int k = 0; k < NUM_OSC; k++) phase[k] <= '0;
    end else begin
      if (trigger && PHASE_RESET != 0) begin
        for (int k = 0; k < NUM_OSC; k++) phase[k] <= '0;
      end else if (bus.sample_clk) begin
        for (int k = 0; k < NUM_OSC; k++) phase[k] <= phase[k] + inc[k];
      end

      // Retrigger keeps the current amplitude so the attack ramps from where it is.
      if (trigger) begin
        state <= ATTACK;
      end else if (bus.tick_clk) begin
        if (rel_now) begin
          amp   <= rel_amp;
          state <= (rel_amp == '0) ? IDLE : RELEASE;
        end else begin
          case (state)
            IDLE: amp <= '0;
            ATTACK: begin
              amp <= att_amp;
              if (att_amp == MAX) state <= DECAY;
            end
            DECAY: begin
              if (dec_amp <= bus.sustain_level) begin
                amp   <= bus.sustain_level;
                state <= SUSTAIN;
              end else begin
                amp <= dec_amp;
              end
            end
            SUSTAIN: amp <= bus.sustain_level;
            default: begin
              amp   <= '0;
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign bus.env_state = state;
  assign bus.busy      = (state != IDLE);
  assign bus.audio_out = mix;
endmodule

// File: tb/tb_pulse_voice_adsr.sv
// tb/tb_pulse_voice_adsr.sv - directed checks of oscillators, envelope and mixing
module tb_pulse_voice_adsr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pulse_voice_adsr_if #(.PHASE_BITS(18), .AMP_BITS(8), .OUT_BITS(13)) bus ();

  pulse_voice_adsr #(
    .PHASE_BITS(18), .NUM_OSC(2), .DETUNE(2), .CARRIER_SHIFT(1),
    .AMP_BITS(8), .OUT_BITS(13), .PHASE_RESET(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic t, input logic trig);
    @(negedge clk);
    bus.sample_clk   = s;
    bus.tick_clk     = t;
    bus.song_clk     = trig;
    bus.note_trigger = trig;
    @(negedge clk);
    bus.sample_clk   = 1'b0;
    bus.tick_clk     = 1'b0;
    bus.song_clk     = 1'b0;
    bus.note_trigger = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.sample_clk = 1'b1;
    bus.tick_clk   = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    bus.sample_clk = 1'b0;
    bus.tick_clk   = 1'b0;
  endtask

  task automatic check_env(input string tag, input logic [7:0] amp, input logic [2:0] st);
    check({tag, "_audio"}, 32'(bus.audio_out), 32'(amp) * 2);
    check({tag, "_state"}, 32'(bus.env_state), 32'(st));
  endtask

  logic [7:0] decay_seq [8] = '{8'h9F, 8'h6F, 8'h57, 8'h4B, 8'h45, 8'h42, 8'h41, 8'h40};
  logic [7:0] rel_seq  [13] = '{8'h30, 8'h24, 8'h1B, 8'h14, 8'h0F, 8'h0B, 8'h08,
                                8'h06, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  initial begin
    int nonzero;
    bus.sample_clk    = 1'b0;
    bus.tick_clk      = 1'b0;
    bus.song_clk      = 1'b0;
    bus.note_on       = 1'b0;
    bus.note_trigger  = 1'b0;
    bus.phase_inc     = '0;
    bus.pulse_width   = 4'd8;
    bus.attack_rate   = 4'd0;
    bus.decay_rate    = 4'd1;
    bus.release_rate  = 4'd2;
    bus.sustain_level = 8'h40;

    do_reset();
    check("rst_audio", 32'(bus.audio_out), 32'd0);
    check("rst_state", 32'(bus.env_state), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_phase0", 32'(dut.phase[0]), 32'd0);

    bus.phase_inc = 18'h100;
    nonzero = 0;
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.audio_out != '0) nonzero++;
      if (i == 511) check("half_phase0", 32'(dut.phase[0]), 32'h20000);
    end
    check("wrap_phase0", 32'(dut.phase[0]), 32'h0);
    check("wrap_phase1", 32'(dut.phase[1]), 32'h800);
    check("silent_amp0", 32'(nonzero), 32'd0);

    do_reset();
    bus.phase_inc = '0;
    bus.note_on   = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    check_env("trig", 8'h00, 3'd1);
    check("trig_busy", 32'(bus.busy), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check_env("attack0", 8'hFF, 3'd2);
    check("both_high", 32'(bus.audio_out), 32'h1FE);
    bus.pulse_width = 4'd0;
    #1 check("pw0_silent", 32'(bus.audio_out), 32'd0);
    bus.pulse_width = 4'd15;
    #1 check("pw15_high", 32'(bus.audio_out), 32'h1FE);
    bus.pulse_width = 4'd8;

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check_env($sformatf("decay%0d", i), decay_seq[i], (i == 7) ? 3'd3 : 3'd2);
    end

    bus.sustain_level = 8'h50;
    step(1'b0, 1'b1, 1'b0);
    check_env("sus_track", 8'h50, 3'd3);
    bus.sustain_level = 8'h40;
    step(1'b0, 1'b1, 1'b0);
    check_env("sus_back", 8'h40, 3'd3);

    bus.note_on = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check_env($sformatf("rel%0d", i), rel_seq[i], (i == 12) ? 3'd0 : 3'd4);
    end
    check("rel_busy0", 32'(bus.busy), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check_env("idle_hold", 8'h00, 3'd0);

    bus.note_on    = 1'b1;
    bus.decay_rate = 4'd0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_env("dr0_sus", 8'h40, 3'd3);
    bus.note_on = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_env("rel_mid", 8'h24, 3'd4);

    bus.note_on     = 1'b1;
    bus.attack_rate = 4'd1;
    bus.phase_inc   = 18'h20000;
    step(1'b1, 1'b1, 1'b1);
    check_env("retrig", 8'h24, 3'd1);
    check("retrig_ph0", 32'(dut.phase[0]), 32'd0);
    check("retrig_ph1", 32'(dut.phase[1]), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check_env("retrig_att", 8'h92, 3'd1);

    bus.phase_inc   = 18'h3C000;
    bus.pulse_width = 4'd15;
    step(1'b1, 1'b0, 1'b0);
    check("top15_ph0", 32'(dut.phase[0]), 32'h3C000);
    check("top15_ph1", 32'(dut.phase[1]), 32'h38002);
    check("top15_audio", 32'(bus.audio_out), 32'h92);

    do_reset();
    check_env("rst2", 8'h00, 3'd0);
    bus.phase_inc = 18'd3;
    step(1'b1, 1'b0, 1'b0);
    check("osc0_inc", 32'(dut.phase[0]), 32'd3);
    check("osc1_inc", 32'(dut.phase[1]), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
